cache_manage_unit: RTL

//  Sequencing controller for the 2-way, 32-set, 4-word-line write-back data cache. Sits between the CPU data port and the cache array/main memory.

---
 rtl/cache_pkg.sv | 36 +++
 rtl/cache_manage_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache sequencing controller:
// address field widths, controller states and access width codes.
package cache_pkg;

    localparam int ADDR_BITS       = 32;
    localparam int TAG_BITS        = 23;
    localparam int SET_INDEX_WIDTH = 5;
    localparam int LINE_WORDS      = 4;
    localparam int WORD_BITS       = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BACK = 2'd1,
        S_FILL = 2'd2,
        S_WAIT = 2'd3
    } state_e;

    // RV32I funct3 width/sign codes
    typedef enum logic [2:0] {
        UBHW_B  = 3'b000,
        UBHW_H  = 3'b001,
        UBHW_W  = 3'b010,
        UBHW_BU = 3'b100,
        UBHW_HU = 3'b101
    } ubhw_e;

    // Word-aligned byte address of one word inside a line
    function automatic logic [ADDR_BITS-1:0] line_addr(
        input logic [TAG_BITS-1:0]        tag,
        input logic [SET_INDEX_WIDTH-1:0] idx,
        input logic [WORD_BITS-1:0]       word
    );
        return {tag, idx, word, 2'b00};
    endfunction

endpackage

// File: rtl/cache_manage_unit.sv
// Sequencing controller for the 2-way write-back data cache:
// serves hits in-cycle, writes back dirty victims, refills lines.
module cache_manage_unit
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_en,
    input  logic                 req_wen,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [31:0]          req_data,
    input  logic [2:0]           req_ubhw,
    output logic [31:0]          req_rdata,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_store,
    output logic                 cache_replace,
    output logic                 cache_invalid,
    output logic [2:0]           cache_ubhw,
    output logic [31:0]          cache_din,
    input  logic                 cache_hit,
    input  logic [31:0]          cache_dout,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack
);

    state_e                      state_q, state_d;
    logic [WORD_BITS-1:0]        word_cnt_q, word_cnt_d;
    logic [TAG_BITS-1:0]         victim_tag_q, victim_tag_d;

    logic [TAG_BITS-1:0]         req_tag;
    logic [SET_INDEX_WIDTH-1:0]  req_idx;
    logic                        last_word;

    assign req_tag   = req_addr[ADDR_BITS-1 -: TAG_BITS];
    assign req_idx   = req_addr[ADDR_BITS-TAG_BITS-1 -: SET_INDEX_WIDTH];
    assign last_word = &word_cnt_q;

    assign stall     = req_en & ~((state_q == S_IDLE) & cache_hit);
    assign req_rdata = cache_dout;
    assign mem_addr  = {cache_addr[ADDR_BITS-1:2], 2'b00};
    assign mem_wdata = cache_dout;

    // Next-state, word counter and all cache/memory strobes
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        victim_tag_d  = victim_tag_q;
        cache_addr    = req_addr;
        cache_ubhw    = req_ubhw;
        cache_din     = req_data;
        cache_load    = 1'b0;
        cache_store   = 1'b0;
        cache_replace = 1'b0;
        cache_invalid = 1'b0;
        mem_cs        = 1'b0;
        mem_we        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_en) begin
                    if (cache_hit) begin
                        cache_load  = ~req_wen;
                        cache_store = req_wen;
                    end else begin
                        victim_tag_d = cache_tag;
                        word_cnt_d   = '0;
                        state_d      = (cache_valid & cache_dirty)
                                     ? S_BACK : S_FILL;
                    end
                end
            end
            S_BACK: begin
                cache_addr = line_addr(victim_tag_q, req_idx, word_cnt_q);
                cache_ubhw = UBHW_W;
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                if (mem_ack) begin
                    word_cnt_d = word_cnt_q + 2'd1;
                    if (last_word) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                cache_addr = line_addr(req_tag, req_idx, word_cnt_q);
                cache_ubhw = UBHW_W;
                cache_din  = mem_rdata;
                mem_cs     = 1'b1;
                if (mem_ack) begin
                    cache_replace = 1'b1;
                    word_cnt_d    = word_cnt_q + 2'd1;
                    if (last_word) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset mid-refill kills the partial line at the in-flight address
        if (rst) begin
            cache_load    = 1'b0;
            cache_store   = 1'b0;
            cache_replace = 1'b0;
            cache_invalid = (state_q == S_FILL);
        end
    end

    // State, word counter and victim tag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_cnt_q   <= '0;
            victim_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            victim_tag_q <= victim_tag_d;
        end
    end

endmodule
